hazard_stall_ctrl: RTL and testbench

//  Pipeline interlock controller; the stall/flush counterpart of the EX forwarding unit.

---
 rtl/hazard_stall_ctrl_if.sv | 35 +++
 rtl/hazard_stall_ctrl.sv | 167 ++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Interface bundling the hazard controller's pipeline-side inputs and its
// enable / status outputs. The master drives the ID/EX hazard inputs and
// observes the enables; the slave is the controller itself.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_ex_memread;
    logic [4:0]       id_ex_rt;
    logic             ex_branch_taken;
    logic             mem_busy;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             pipe_freeze;
    logic [CNT_W-1:0] stall_count;
    logic             mem_timeout;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_ex_memread, id_ex_rt,
               ex_branch_taken, mem_busy,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
               pipe_freeze, stall_count, mem_timeout
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_ex_memread, id_ex_rt,
               ex_branch_taken, mem_busy,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble,
               pipe_freeze, stall_count, mem_timeout
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock controller: resolves load-use stalls, taken-branch
// flushes and multi-cycle data-memory freezes that forwarding cannot cover.
// Enables are combinational from the FSM state and the current hazard inputs;
// a saturating stall counter and a sticky memory-timeout flag are kept alongside.
module hazard_stall_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_stall_ctrl_if.slave bus
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam int BC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [1:0] ST_BOOT    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;
    localparam logic [1:0] ST_MEMWAIT = 2'd3;

    localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [BC_W-1:0] BUSY_LAST  = BC_W'(MEM_TIMEOUT - 1);
    localparam logic [BC_W-1:0] BUSY_MAX   = BC_W'(MEM_TIMEOUT);

    logic [1:0]       state_r;
    logic [1:0]       state_nx_s;
    logic [FC_W-1:0]  flush_cnt_r;
    logic [FC_W-1:0]  flush_cnt_nx_s;
    logic [BC_W-1:0]  busy_cnt_r;
    logic [CNT_W-1:0] stall_count_r;
    logic             mem_timeout_r;

    logic             load_use_s;
    logic             pc_write_s;
    logic             if_id_write_s;
    logic             if_id_flush_s;
    logic             id_ex_bubble_s;
    logic             pipe_freeze_s;
    logic             stall_evt_s;

    // Load in EX whose destination feeds the ID instruction; r0 is never a real dependence.
    assign load_use_s = bus.id_ex_memread && (bus.id_ex_rt != 5'd0) &&
                        ((bus.id_ex_rt == bus.id_rs) ||
                         (bus.id_uses_rt && (bus.id_ex_rt == bus.id_rt)));

    // State decode: enables and next state; priority is freeze > branch > load-use.
    always_comb begin
        pc_write_s     = 1'b0;
        if_id_write_s  = 1'b0;
        if_id_flush_s  = 1'b0;
        id_ex_bubble_s = 1'b0;
        pipe_freeze_s  = 1'b0;
        state_nx_s     = state_r;
        flush_cnt_nx_s = flush_cnt_r;
        case (state_r)
            ST_BOOT: begin
                if_id_flush_s  = 1'b1;
                id_ex_bubble_s = 1'b1;
                state_nx_s     = ST_RUN;
            end
            // MEMWAIT on release behaves exactly like RUN, so a branch held
            // in EX through the freeze gets its full flush sequence.
            ST_RUN, ST_MEMWAIT: begin
                if (bus.mem_busy) begin
                    pipe_freeze_s = 1'b1;
                    state_nx_s    = ST_MEMWAIT;
                end else if (bus.ex_branch_taken) begin
                    pc_write_s     = 1'b1;
                    if_id_flush_s  = 1'b1;
                    id_ex_bubble_s = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_nx_s     = ST_FLUSH;
                        flush_cnt_nx_s = FLUSH_LOAD;
                    end else begin
                        state_nx_s     = ST_RUN;
                    end
                end else if (load_use_s) begin
                    id_ex_bubble_s = 1'b1;
                    state_nx_s     = ST_RUN;
                end else begin
                    pc_write_s    = 1'b1;
                    if_id_write_s = 1'b1;
                    state_nx_s    = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (bus.mem_busy) begin
                    pipe_freeze_s = 1'b1;
                end else begin
                    pc_write_s     = 1'b1;
                    if_id_flush_s  = 1'b1;
                    id_ex_bubble_s = 1'b1;
                    if (flush_cnt_r <= FC_W'(1)) begin
                        state_nx_s     = ST_RUN;
                        flush_cnt_nx_s = {FC_W{1'b0}};
                    end else begin
                        flush_cnt_nx_s = flush_cnt_r - FC_W'(1);
                    end
                end
            end
            default: begin
                if_id_flush_s  = 1'b1;
                id_ex_bubble_s = 1'b1;
                state_nx_s     = ST_BOOT;
            end
        endcase
    end

    // Any cycle that is not a plain advance counts once; the BOOT cycle is excluded.
    assign stall_evt_s = (state_r != ST_BOOT) &&
                         (!pc_write_s || if_id_flush_s || pipe_freeze_s);

    // FSM state and remaining flush cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_BOOT;
            flush_cnt_r <= {FC_W{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            flush_cnt_r <= flush_cnt_nx_s;
        end
    end

    // Consecutive mem_busy run length and the sticky timeout flag it raises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt_r    <= {BC_W{1'b0}};
            mem_timeout_r <= 1'b0;
        end else if (bus.mem_busy) begin
            if (busy_cnt_r == BUSY_LAST) begin
                mem_timeout_r <= 1'b1;
            end else begin
                mem_timeout_r <= mem_timeout_r;
            end
            if (busy_cnt_r != BUSY_MAX) begin
                busy_cnt_r <= busy_cnt_r + BC_W'(1);
            end else begin
                busy_cnt_r <= busy_cnt_r;
            end
        end else begin
            busy_cnt_r    <= {BC_W{1'b0}};
            mem_timeout_r <= mem_timeout_r;
        end
    end

    // Saturating count of stall / flush / freeze cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (stall_evt_s && (stall_count_r != {CNT_W{1'b1}})) begin
            stall_count_r <= stall_count_r + CNT_W'(1);
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign bus.pc_write     = pc_write_s;
    assign bus.if_id_write  = if_id_write_s;
    assign bus.if_id_flush  = if_id_flush_s;
    assign bus.id_ex_bubble = id_ex_bubble_s;
    assign bus.pipe_freeze  = pipe_freeze_s;
    assign bus.stall_count  = stall_count_r;
    assign bus.mem_timeout  = mem_timeout_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=8).
// Each driven cycle pushes its expected enables, stall count and timeout flag
// into a scoreboard; a negedge monitor pops and compares them.
module tb_hazard_stall_ctrl;

    localparam int CNT_W = 16;

    // Expected enables packed as {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze}
    localparam logic [4:0] E_BOOT = 5'b00110;
    localparam logic [4:0] E_NORM = 5'b11000;
    localparam logic [4:0] E_LU   = 5'b00010;
    localparam logic [4:0] E_BR   = 5'b10110;
    localparam logic [4:0] E_FRZ  = 5'b00001;

    typedef struct {
        logic [4:0]       en;
        logic [CNT_W-1:0] cnt;
        logic             to;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb_q[$];
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_to;

    hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_stall_ctrl #(
        .FLUSH_CYCLES(2),
        .MEM_TIMEOUT (8),
        .CNT_W       (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard monitor: compare DUT outputs mid-cycle against the queued expectation.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check_val("pc_write",     {31'd0, bus.pc_write},     {31'd0, e.en[4]});
            check_val("if_id_write",  {31'd0, bus.if_id_write},  {31'd0, e.en[3]});
            check_val("if_id_flush",  {31'd0, bus.if_id_flush},  {31'd0, e.en[2]});
            check_val("id_ex_bubble", {31'd0, bus.id_ex_bubble}, {31'd0, e.en[1]});
            check_val("pipe_freeze",  {31'd0, bus.pipe_freeze},  {31'd0, e.en[0]});
            check_val("stall_count",  {16'd0, bus.stall_count},  {16'd0, e.cnt});
            check_val("mem_timeout",  {31'd0, bus.mem_timeout},  {31'd0, e.to});
        end
    end

    // Drive one cycle of inputs, queue its expectation, then advance past the next edge.
    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                        input logic memread, input logic [4:0] exrt, input logic br,
                        input logic busy, input logic [4:0] en, input logic boot);
        exp_t e;
        bus.id_rs           = rs;
        bus.id_rt           = rt;
        bus.id_uses_rt      = uses_rt;
        bus.id_ex_memread   = memread;
        bus.id_ex_rt        = exrt;
        bus.ex_branch_taken = br;
        bus.mem_busy        = busy;
        e.en  = en;
        e.cnt = exp_cnt;
        e.to  = exp_to;
        sb_q.push_back(e);
        if (!boot && (!en[4] || en[2] || en[0])) begin
            exp_cnt = exp_cnt + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 16'd0;
        exp_to  = 1'b0;
        rst_n   = 1'b0;
        bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_uses_rt = 1'b0;
        bus.id_ex_memread = 1'b0; bus.id_ex_rt = 5'd0;
        bus.ex_branch_taken = 1'b0; bus.mem_busy = 1'b0;

        // Outputs at BOOT values while held in reset.
        #12;
        check_val("rst_pc_write",    {31'd0, bus.pc_write},    32'd0);
        check_val("rst_if_id_flush", {31'd0, bus.if_id_flush}, 32'd1);
        check_val("rst_stall_count", {16'd0, bus.stall_count}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // BOOT cycle, then quiet RUN and non-hazard patterns.
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_BOOT, 1'b1);
        step(5'd1, 5'd2, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, E_NORM, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, E_NORM, 1'b0);   // r0 load
        step(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, E_NORM, 1'b0);   // rt not used
        step(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, E_LU,   1'b0);   // rt used -> stall
        step(5'd3, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, E_NORM, 1'b0);

        // Load-use on rs: one stall cycle, bubble clears memread afterwards.
        step(5'd5, 5'd9, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, E_LU,   1'b0);
        step(5'd5, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_NORM, 1'b0);

        // Taken branch: two flush cycles; load-use ignored in FLUSH.
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, E_BR,   1'b0);
        step(5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, E_BR,   1'b0);
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_NORM, 1'b0);

        // Load-use and branch together: branch wins.
        step(5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, E_BR,   1'b0);
        step(5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, E_BR,   1'b0);
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_NORM, 1'b0);

        // Memory wait with a branch held in EX: 4 freeze cycles, flush on release.
        for (int i = 0; i < 4; i++) begin
            step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, E_FRZ, 1'b0);
        end
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, E_BR,   1'b0);
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_BR,   1'b0);
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_NORM, 1'b0);

        // mem_busy during FLUSH freezes and holds the remaining flush cycle.
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, E_BR,   1'b0);
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, E_FRZ,  1'b0);
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_BR,   1'b0);
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_NORM, 1'b0);

        // Timeout: 10 busy cycles; flag visible from the 9th cycle, sticky afterwards.
        for (int i = 1; i <= 10; i++) begin
            if (i == 9) exp_to = 1'b1;
            step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, E_FRZ, 1'b0);
        end
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_NORM, 1'b0);
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_NORM, 1'b0);

        // Reset mid-FLUSH: BOOT values and cleared counters immediately.
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, E_BR, 1'b0);
        check_val("flush_before_rst", {31'd0, bus.if_id_flush}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_pc_write",     {31'd0, bus.pc_write},     32'd0);
        check_val("rst_mid_if_id_write",  {31'd0, bus.if_id_write},  32'd0);
        check_val("rst_mid_if_id_flush",  {31'd0, bus.if_id_flush},  32'd1);
        check_val("rst_mid_id_ex_bubble", {31'd0, bus.id_ex_bubble}, 32'd1);
        check_val("rst_mid_pipe_freeze",  {31'd0, bus.pipe_freeze},  32'd0);
        check_val("rst_mid_stall_count",  {16'd0, bus.stall_count},  32'd0);
        check_val("rst_mid_mem_timeout",  {31'd0, bus.mem_timeout},  32'd0);
        exp_cnt = 16'd0;
        exp_to  = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_BOOT, 1'b1);
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_NORM, 1'b0);
        step(5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, E_LU,   1'b0);
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_NORM, 1'b0);

        check_val("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
